spi_fifo_wm: RTL

//  Parametrised synchronous FIFO for the SPI datapath (TX/RX staging between register bus and shifter).

---
 rtl/spi_fifo_wm.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_fifo_wm.sv
// spi_fifo_wm: synchronous valid/ready FIFO for SPI TX/RX staging, any depth >= 2.
// Ports: push side (valid_i/data_i/ready_o), fall-through pop side (valid_o/data_o/ready_i),
//        clr_i flush, occupancy/free counts, runtime watermark flags, sticky errors, high-water mark.
module spi_fifo_wm #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter int unsigned CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i,
    output logic [CNT_W-1:0]      elements_o,
    output logic [CNT_W-1:0]      free_o,
    input  logic [CNT_W-1:0]      afull_thr_i,
    input  logic [CNT_W-1:0]      aempty_thr_i,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    input  logic                  err_clr_i,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [CNT_W-1:0]      hwm_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUFFER_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      elements_q, elements_d;
    logic [CNT_W-1:0]      hwm_q, hwm_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty, push, pop;

    // Full/empty come only from registered occupancy, so no ready_i->ready_o
    // or valid_i->valid_o combinational path exists.
    assign full  = (elements_q == DEPTH_C);
    assign empty = (elements_q == '0);
    assign push  = valid_i & ~full;
    assign pop   = ready_i & ~empty;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        elements_d  = elements_q;
        hwm_d       = hwm_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr_i) begin
            // Flush wins over everything; storage is left stale.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            elements_d  = '0;
            hwm_d       = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   elements_d = elements_q + 1'b1;
                2'b01:   elements_d = elements_q - 1'b1;
                default: elements_d = elements_q;
            endcase
            if (elements_d > hwm_q) begin
                hwm_d = elements_d;
            end
            // A fresh error in the clear cycle keeps the flag set.
            overflow_d  = (overflow_q & ~err_clr_i) | (valid_i & full);
            underflow_d = (underflow_q & ~err_clr_i) | (ready_i & empty);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            elements_q  <= '0;
            hwm_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            elements_q  <= elements_d;
            hwm_q       <= hwm_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign ready_o        = ~full;
    assign valid_o        = ~empty;
    assign data_o         = mem_q[rd_ptr_q];
    assign elements_o     = elements_q;
    assign free_o         = DEPTH_C - elements_q;
    assign almost_full_o  = (elements_q >= afull_thr_i);
    assign almost_empty_o = (elements_q <= aempty_thr_i);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
    assign hwm_o          = hwm_q;

endmodule
